// File: rtl/lfsr8_pkg.sv
// rtl/lfsr8_pkg.sv - shared LFSR8 next-state function, constants and checker state enum
package lfsr8_pkg;

    localparam logic [7:0] LFSR8_ZERO = 8'h00;
    localparam logic [7:0] LFSR8_ONES = 8'hff;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lfsr8_state_t;

    // The all-ones state is swapped for zero so the sequence also visits 8'h00.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        logic [7:0] t;
        logic [7:0] r;
        t = {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
        if (s == LFSR8_ZERO) begin
            r = LFSR8_ONES;
        end else if (t == LFSR8_ONES) begin
            r = LFSR8_ZERO;
        end else begin
            r = t;
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr8_checker.sv
// rtl/lfsr8_checker.sv - LFSR8 sequence checker with self-sync lock and error counting
// Optional macro LFSR8_CHK_STATS_EN adds word_count output.
module lfsr8_checker
    import lfsr8_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
`ifdef LFSR8_CHK_STATS_EN
    ,
    output logic [CNT_W-1:0] word_count
`endif
);

    localparam logic [4:0] LOCK_N = 5'(LOCK_COUNT);
    localparam logic [4:0] LOSS_N = 5'(LOSS_COUNT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    lfsr8_state_t     state_q, state_d;
    logic             have_ref_q, have_ref_d;
    logic [7:0]       pred_q, pred_d;
    logic [3:0]       match_run_q, match_run_d;
    logic [3:0]       bad_run_q, bad_run_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
`ifdef LFSR8_CHK_STATS_EN
    logic [CNT_W-1:0] word_count_q, word_count_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            have_ref_q  <= 1'b0;
            pred_q      <= LFSR8_ZERO;
            match_run_q <= 4'd0;
            bad_run_q   <= 4'd0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
`ifdef LFSR8_CHK_STATS_EN
            word_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            have_ref_q  <= have_ref_d;
            pred_q      <= pred_d;
            match_run_q <= match_run_d;
            bad_run_q   <= bad_run_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
`ifdef LFSR8_CHK_STATS_EN
            word_count_q <= word_count_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        have_ref_d  = have_ref_q;
        pred_d      = pred_q;
        match_run_d = match_run_q;
        bad_run_d   = bad_run_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
`ifdef LFSR8_CHK_STATS_EN
        word_count_d = word_count_q;
`endif
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    // Hunting always reseeds from the received byte.
                    pred_d = lfsr8_next(in_data);
                    if (!have_ref_q) begin
                        have_ref_d  = 1'b1;
                        match_run_d = 4'd0;
                    end else if (in_data == pred_q) begin
                        match_run_d = match_run_q + 4'd1;
                        if ({1'b0, match_run_q} + 5'd1 == LOCK_N) begin
                            state_d   = LOCKED;
                            bad_run_d = 4'd0;
                        end
                    end else begin
                        match_run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction advances from itself, never from the input.
                    pred_d = lfsr8_next(pred_q);
`ifdef LFSR8_CHK_STATS_EN
                    word_count_d = sat_inc(word_count_q);
`endif
                    if (in_data == pred_q) begin
                        bad_run_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_count_d = sat_inc(err_count_q);
                        bad_run_d   = bad_run_q + 4'd1;
                        if ({1'b0, bad_run_q} + 5'd1 == LOSS_N) begin
                            state_d     = HUNT;
                            have_ref_d  = 1'b0;
                            match_run_d = 4'd0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (clear_cnt) begin
            err_count_d = '0;
`ifdef LFSR8_CHK_STATS_EN
            word_count_d = '0;
`endif
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
`ifdef LFSR8_CHK_STATS_EN
    assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_lfsr8_checker.sv
// tb/tb_lfsr8_checker.sv - scoreboard bench for lfsr8_checker (default and small-counter instances)
module tb_lfsr8_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       clear_cnt = 1'b0;

    logic        a_locked, a_err_pulse;
    logic [15:0] a_err_count;
    logic        b_locked, b_err_pulse;
    logic [3:0]  b_err_count;
`ifdef LFSR8_CHK_STATS_EN
    logic [15:0] a_word_count;
    logic [3:0]  b_word_count;
`endif

    always #5 clk = ~clk;

    lfsr8_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear_cnt(clear_cnt),
        .locked(a_locked), .err_pulse(a_err_pulse), .err_count(a_err_count)
`ifdef LFSR8_CHK_STATS_EN
        , .word_count(a_word_count)
`endif
    );

    lfsr8_checker #(.LOCK_COUNT(4), .LOSS_COUNT(15), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear_cnt(clear_cnt),
        .locked(b_locked), .err_pulse(b_err_pulse), .err_count(b_err_count)
`ifdef LFSR8_CHK_STATS_EN
        , .word_count(b_word_count)
`endif
    );

    typedef struct {
        bit         hunt;
        bit         have_ref;
        logic [7:0] pred;
        int         mrun;
        int         brun;
        bit         pulse;
        int         cnt;
        int         wcnt;
    } model_t;

    typedef struct {
        bit locked;
        bit pulse;
        int cnt;
        int wcnt;
    } exp_t;

    model_t ma, mb;
    exp_t   qa[$];
    exp_t   qb[$];
    int     n_checks = 0;
    int     n_errors = 0;
    logic [7:0] g = 8'h00;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_next(input logic [7:0] s);
        logic [7:0] t;
        if (s == 8'h00) return 8'hff;
        t = {^(s & 8'b0001_1101), s[7:1]};
        if (t == 8'hff) return 8'h00;
        return t;
    endfunction

    function automatic model_t mstep(input model_t m, input bit r, input bit v, input logic [7:0] d,
                                     input bit c, input int lockc, input int lossc, input int maxc);
        model_t n;
        n = m;
        n.pulse = 1'b0;
        if (r) begin
            n.hunt = 1'b1; n.have_ref = 1'b0; n.pred = 8'h00;
            n.mrun = 0; n.brun = 0; n.cnt = 0; n.wcnt = 0;
            return n;
        end
        if (v) begin
            if (m.hunt) begin
                n.pred = ref_next(d);
                if (!m.have_ref) begin
                    n.have_ref = 1'b1;
                    n.mrun = 0;
                end else if (d == m.pred) begin
                    n.mrun = m.mrun + 1;
                    if (n.mrun == lockc) begin
                        n.hunt = 1'b0;
                        n.brun = 0;
                    end
                end else begin
                    n.mrun = 0;
                end
            end else begin
                n.pred = ref_next(m.pred);
                if (n.wcnt < maxc) n.wcnt++;
                if (d == m.pred) begin
                    n.brun = 0;
                end else begin
                    n.pulse = 1'b1;
                    if (n.cnt < maxc) n.cnt++;
                    n.brun = m.brun + 1;
                    if (n.brun == lossc) begin
                        n.hunt = 1'b1;
                        n.have_ref = 1'b0;
                        n.mrun = 0;
                    end
                end
            end
        end
        if (c) begin
            n.cnt = 0;
            n.wcnt = 0;
        end
        return n;
    endfunction

    function automatic exp_t to_exp(input model_t m);
        exp_t e;
        e.locked = !m.hunt;
        e.pulse  = m.pulse;
        e.cnt    = m.cnt;
        e.wcnt   = m.wcnt;
        return e;
    endfunction

    task automatic cyc(input bit r, input bit v, input logic [7:0] d, input bit c);
        exp_t ea, eb;
        rst = r; in_valid = v; in_data = d; clear_cnt = c;
        ma = mstep(ma, r, v, d, c, 4, 3, 65535);
        mb = mstep(mb, r, v, d, c, 4, 15, 15);
        qa.push_back(to_exp(ma));
        qb.push_back(to_exp(mb));
        @(posedge clk);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        check("a_locked", a_locked, ea.locked);
        check("a_err_pulse", a_err_pulse, ea.pulse);
        check("a_err_count", a_err_count, ea.cnt);
        check("b_locked", b_locked, eb.locked);
        check("b_err_pulse", b_err_pulse, eb.pulse);
        check("b_err_count", b_err_count, eb.cnt);
`ifdef LFSR8_CHK_STATS_EN
        check("a_word_count", a_word_count, ea.wcnt);
        check("b_word_count", b_word_count, eb.wcnt);
`endif
        rst = 1'b0; in_valid = 1'b0; clear_cnt = 1'b0;
    endtask

    task automatic send_good();
        cyc(1'b0, 1'b1, g, 1'b0);
        g = ref_next(g);
    endtask

    task automatic send_bad();
        cyc(1'b0, 1'b1, g ^ 8'h01, 1'b0);
        g = ref_next(g);
    endtask

    task automatic gap();
        cyc(1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    initial begin
        int  saved;
        bit  seen_fe;
        bit  done;
        logic [7:0] prev;

        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, 8'h00, 1'b0);
        check("reset_locked", a_locked, 0);
        check("reset_err_count", a_err_count, 0);

        // Lock acquisition on 00,ff,7f,3f,1f.
        g = 8'h00;
        repeat (4) send_good();
        check("pre_lock", a_locked, 0);
        check("lock_byte", in_data, 8'h3f);
        send_good();
        check("lock_acq", a_locked, 1);
        check("lock_err0", a_err_count, 0);

        // Single error: 0f, 86 (instead of 87), 43.
        send_good();
        cyc(1'b0, 1'b1, 8'h86, 1'b0);
        g = ref_next(g);
        check("single_pulse", a_err_pulse, 1);
        check("single_cnt", a_err_count, 1);
        cyc(1'b0, 1'b1, 8'h43, 1'b0);
        g = ref_next(g);
        check("single_locked", a_locked, 1);
        check("single_nopulse", a_err_pulse, 0);

        // Loss of lock after three aa bytes, then relock.
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (3) begin
            cyc(1'b0, 1'b1, 8'haa, 1'b0);
            g = ref_next(g);
        end
        check("loss_cnt", a_err_count, 3);
        check("loss_unlocked", a_locked, 0);
        check("loss_b_stays", b_locked, 1);
        repeat (4) send_good();
        check("relock_not_yet", a_locked, 0);
        send_good();
        check("relock", a_locked, 1);

        // Wrap fe,00,ff with idle gaps between every byte.
        saved = a_err_count;
        seen_fe = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            prev = g;
            send_good();
            gap();
            if (prev == 8'hfe) seen_fe = 1'b1;
            if (seen_fe && prev == 8'hff) done = 1'b1;
        end
        check("wrap_seen", done, 1);
        check("wrap_locked", a_locked, 1);
        check("wrap_no_err", a_err_count, saved);

        // Saturation on the 4-bit instance: 20 errors without dropping lock.
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (14) send_bad();
        send_good();
        repeat (6) send_bad();
        check("sat_cnt", b_err_count, 15);
        check("sat_locked", b_locked, 1);
        cyc(1'b0, 1'b1, g ^ 8'h01, 1'b1);
        g = ref_next(g);
        check("clr_pri_cnt", b_err_count, 0);
        check("clr_pri_pulse", b_err_pulse, 1);

        // Reset while locked with five counted errors.
        repeat (8) send_good();
        check("resync_lock", a_locked, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (5) begin
            send_bad();
            send_good();
        end
        check("pre_rst_cnt", a_err_count, 5);
        check("pre_rst_locked", a_locked, 1);
        cyc(1'b1, 1'b1, g, 1'b0);
        check("rst_locked", a_locked, 0);
        check("rst_cnt", a_err_count, 0);
        check("rst_b_locked", b_locked, 0);
        g = 8'h5a;
        repeat (4) send_good();
        check("reseed_not_yet", a_locked, 0);
        send_good();
        check("reseed_lock", a_locked, 1);
        check("reseed_cnt", a_err_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
